// File: rtl/sda_pdm_decoder_if.sv
// Sample-side bundle of the PDM decoder: bit strobe/data in, valid/ready PCM out, drop telemetry.
interface sda_pdm_decoder_if #(
  parameter int OUT_W = 16
);
  logic             bit_en;
  logic             pdm_in;
  logic [OUT_W-1:0] sample_out;
  logic             sample_valid;
  logic             sample_ready;
  logic             overrun;
  logic [7:0]       drop_cnt;

  modport master (
    input  bit_en, pdm_in, sample_ready,
    output sample_out, sample_valid, overrun, drop_cnt
  );

  modport slave (
    output bit_en, pdm_in, sample_ready,
    input  sample_out, sample_valid, overrun, drop_cnt
  );
endinterface

// File: rtl/sda_pdm_decoder.sv
// sinc^3 CIC PDM-to-PCM decoder; sample_valid rises 2 clk after the decimating bit_en edge.
// One-entry output buffer: a new sample overwrites an unaccepted one and counts a drop.
module sda_pdm_decoder #(
  parameter int DECIM = 64,
  parameter int OUT_W = 16
) (
  input logic              clk,
  input logic              rst,
  sda_pdm_decoder_if.master bus
);
  localparam int LD = $clog2(DECIM);
  localparam int W  = 3 * LD + 1;
  localparam int SH = W - OUT_W;

  logic [W-1:0]     x;
  logic [W-1:0]     i1_q, i2_q, i3_q;
  logic [W-1:0]     i1_d, i2_d, i3_d;
  logic [LD-1:0]    dcnt_q;
  logic             cap_vld_q;
  logic [W-1:0]     cap_q;
  logic             cap_bit_q;
  logic [W-1:0]     d1_q, d2_q, d3_q;
  logic [W-1:0]     c1, c2, c3;
  logic [W-1:0]     comb_q;
  logic             comb_pos_q;
  logic             comb_vld_q;
  logic [1:0]       warm_q;
  logic [OUT_W-1:0] y;
  logic             sat;
  logic [OUT_W-1:0] out_q;
  logic             vld_q;
  logic             ovr_q;
  logic [7:0]       drop_q;

  assign x    = bus.pdm_in ? W'(1) : '1;
  assign i1_d = i1_q + x;
  assign i2_d = i2_q + i1_d;
  assign i3_d = i3_q + i2_d;

  assign c1 = cap_q - d1_q;
  assign c2 = c1 - d2_q;
  assign c3 = c2 - d3_q;

  // +2^(W-1) and -2^(W-1) share one W-bit pattern; the newest input bit (tap weight 1) tells them apart.
  assign sat = comb_pos_q && (comb_q == {1'b1, {(W-1){1'b0}}});
  assign y   = sat ? {1'b0, {(OUT_W-1){1'b1}}} : comb_q[W-1:SH];

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q       <= '0;
      i2_q       <= '0;
      i3_q       <= '0;
      dcnt_q     <= '0;
      cap_vld_q  <= 1'b0;
      cap_q      <= '0;
      cap_bit_q  <= 1'b0;
      d1_q       <= '0;
      d2_q       <= '0;
      d3_q       <= '0;
      comb_q     <= '0;
      comb_pos_q <= 1'b0;
      comb_vld_q <= 1'b0;
      warm_q     <= '0;
      out_q      <= '0;
      vld_q      <= 1'b0;
      ovr_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      cap_vld_q <= 1'b0;
      if (bus.bit_en) begin
        i1_q   <= i1_d;
        i2_q   <= i2_d;
        i3_q   <= i3_d;
        dcnt_q <= dcnt_q + LD'(1);
        if (&dcnt_q) begin
          cap_vld_q <= 1'b1;
          cap_q     <= i3_d;
          cap_bit_q <= bus.pdm_in;
        end
      end

      comb_vld_q <= 1'b0;
      if (cap_vld_q) begin
        d1_q       <= cap_q;
        d2_q       <= c1;
        d3_q       <= c2;
        comb_q     <= c3;
        comb_pos_q <= cap_bit_q;
        if (warm_q == 2'd3) comb_vld_q <= 1'b1;
        else                warm_q     <= warm_q + 2'd1;
      end

      ovr_q <= 1'b0;
      if (comb_vld_q) begin
        out_q <= y;
        vld_q <= 1'b1;
        if (vld_q && !bus.sample_ready) begin
          ovr_q <= 1'b1;
          if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
      end else if (vld_q && bus.sample_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.sample_out   = out_q;
  assign bus.sample_valid = vld_q;
  assign bus.overrun      = ovr_q;
  assign bus.drop_cnt     = drop_q;
endmodule

// File: tb/tb_sda_pdm_decoder.sv
// Bench for sda_pdm_decoder: random/patterned PDM streams checked against a direct sinc^3 FIR model.
module tb_sda_pdm_decoder;
  localparam int D     = 64;
  localparam int W     = 19;
  localparam int OUT_W = 16;
  localparam int NH    = 3 * D - 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sda_pdm_decoder_if #(.OUT_W(OUT_W)) bus ();

  sda_pdm_decoder #(.DECIM(D), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     vec, miss;
  int     cyc;
  longint h[NH];
  int     hist[$];
  int     ndec;
  int     exp_q[$], got_q[$];
  int     exp_rise_q[$], rise_q[$];
  int     ovr_cnt;
  bit     prev_v;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.sample_valid && !prev_v) rise_q.push_back(cyc);
    if (bus.sample_valid && bus.sample_ready) got_q.push_back(int'($signed(bus.sample_out)));
    if (bus.overrun) ovr_cnt++;
    prev_v = bus.sample_valid;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // sinc^3 impulse response = count of (a,b,c) in [0,D)^3 summing to j
  task automatic build_h();
    for (int j = 0; j < NH; j++) begin
      h[j] = 0;
      for (int a = 0; a < D; a++)
        for (int b = 0; b < D; b++)
          if (j - a - b >= 0 && j - a - b < D) h[j]++;
    end
  endtask

  function automatic int model_sample();
    longint c = 0;
    int     n = hist.size();
    for (int j = 0; j < NH; j++)
      if (n - 1 - j >= 0) c += h[j] * longint'(hist[n-1-j]);
    if (c >= (longint'(1) << (W - 1))) return (1 << (OUT_W - 1)) - 1;
    return int'(c >>> (W - OUT_W));
  endfunction

  function automatic bit pat_bit(input int kind, input int i);
    case (kind)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return bit'((i % 4) != 3);
      3:       return bit'((i % 2) == 0);
      default: return bit'($urandom_range(1, 0));
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.bit_en = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    hist.delete();
    exp_q.delete();
    got_q.delete();
    exp_rise_q.delete();
    rise_q.delete();
    ndec    = 0;
    ovr_cnt = 0;
  endtask

  task automatic send_bit(input bit b, input int gap);
    tick(gap);
    bus.bit_en = 1'b1;
    bus.pdm_in = b;
    tick(1);
    bus.bit_en = 1'b0;
    hist.push_back(b ? 1 : -1);
    if (hist.size() % D == 0) begin
      ndec++;
      if (ndec >= 4) begin
        exp_q.push_back(model_sample());
        exp_rise_q.push_back(cyc + 2);
      end
    end
  endtask

  task automatic test_reset();
    bus.sample_ready = 1'b1;
    bus.pdm_in       = 1'b0;
    do_reset();
    tick(1);
    vec++; if (bus.sample_valid !== 1'b0) begin miss++; $display("FAIL reset_valid: got %0b want 0", bus.sample_valid); end
    vec++; if (bus.sample_out !== '0) begin miss++; $display("FAIL reset_out: got %h want 0000", bus.sample_out); end
    vec++; if (bus.overrun !== 1'b0) begin miss++; $display("FAIL reset_overrun: got %0b want 0", bus.overrun); end
    vec++; if (bus.drop_cnt !== 8'd0) begin miss++; $display("FAIL reset_drop: got %0d want 0", bus.drop_cnt); end
  endtask

  // gap < 0 selects a random 0..3 idle clocks before every bit
  task automatic test_stream(input string name, input int kind, input int gap, input int nbits,
                             input bit use_const, input int cval);
    do_reset();
    bus.sample_ready = 1'b1;
    for (int i = 0; i < nbits; i++)
      send_bit(pat_bit(kind, i), (gap < 0) ? int'($urandom_range(3, 0)) : gap);
    tick(4);
    vec++; if (got_q.size() != exp_q.size()) begin miss++; $display("FAIL %s count: got %0d want %0d", name, got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      vec++; if (got_q[i] !== exp_q[i]) begin miss++; $display("FAIL %s sample%0d: got %0d want %0d", name, i, got_q[i], exp_q[i]); end
      if (use_const) begin
        vec++; if (got_q[i] !== cval) begin miss++; $display("FAIL %s level%0d: got %0d want %0d", name, i, got_q[i], cval); end
      end
    end
    vec++; if (rise_q.size() != exp_rise_q.size()) begin miss++; $display("FAIL %s rises: got %0d want %0d", name, rise_q.size(), exp_rise_q.size()); end
    foreach (exp_rise_q[i]) if (i < rise_q.size()) begin
      vec++; if (rise_q[i] !== exp_rise_q[i]) begin miss++; $display("FAIL %s latency%0d: got cyc %0d want cyc %0d", name, i, rise_q[i], exp_rise_q[i]); end
    end
    vec++; if (ovr_cnt !== 0) begin miss++; $display("FAIL %s overrun: got %0d pulses want 0", name, ovr_cnt); end
  endtask

  task automatic test_dc_levels();
    test_stream("all_ones", 0, 0, 8 * D, 1'b1, 32767);
    test_stream("all_zeros", 1, 0, 8 * D, 1'b1, -32768);
  endtask

  task automatic test_patterns();
    test_stream("pat_1110", 2, 0, 8 * D, 1'b1, 16384);
    test_stream("pat_10", 3, 0, 8 * D, 1'b1, 0);
  endtask

  task automatic test_bit_en_gaps();
    test_stream("gap3_1110", 2, 2, 8 * D, 1'b1, 16384);
  endtask

  task automatic test_random();
    test_stream("random", 4, -1, 12 * D, 1'b0, 0);
  endtask

  task automatic test_overrun();
    do_reset();
    bus.sample_ready = 1'b1;
    for (int i = 0; i < 4 * D; i++) send_bit(pat_bit(4, i), 0);
    tick(3);
    bus.sample_ready = 1'b0;
    for (int i = 0; i < 3 * D; i++) send_bit(pat_bit(4, i), 0);
    tick(3);
    vec++; if (bus.sample_valid !== 1'b1) begin miss++; $display("FAIL ovr_valid: got %0b want 1", bus.sample_valid); end
    vec++; if (ovr_cnt !== 2) begin miss++; $display("FAIL ovr_pulses: got %0d want 2", ovr_cnt); end
    vec++; if (bus.drop_cnt !== 8'd2) begin miss++; $display("FAIL ovr_drop: got %0d want 2", bus.drop_cnt); end
    vec++; if (int'($signed(bus.sample_out)) !== exp_q[$]) begin miss++; $display("FAIL ovr_newest: got %0d want %0d", $signed(bus.sample_out), exp_q[$]); end
    // release ready exactly on the next load cycle: transfer plus load, no overrun
    for (int i = 0; i < D; i++) send_bit(pat_bit(4, i), 0);
    tick(1);
    bus.sample_ready = 1'b1;
    tick(1);
    vec++; if (bus.sample_valid !== 1'b1) begin miss++; $display("FAIL ld_xfer_valid: got %0b want 1", bus.sample_valid); end
    vec++; if (int'($signed(bus.sample_out)) !== exp_q[$]) begin miss++; $display("FAIL ld_xfer_out: got %0d want %0d", $signed(bus.sample_out), exp_q[$]); end
    vec++; if (bus.drop_cnt !== 8'd2 || ovr_cnt !== 2) begin miss++; $display("FAIL ld_xfer_drop: got drop %0d pulses %0d want 2/2", bus.drop_cnt, ovr_cnt); end
    tick(1);
    vec++; if (bus.sample_valid !== 1'b0) begin miss++; $display("FAIL ready_drop: got %0b want 0", bus.sample_valid); end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    bus.sample_ready = 1'b0;
    for (int i = 0; i < 262 * D; i++) send_bit(1'b1, 0);
    tick(3);
    vec++; if (bus.drop_cnt !== 8'd255) begin miss++; $display("FAIL drop_sat: got %0d want 255", bus.drop_cnt); end
    vec++; if (ovr_cnt !== 258) begin miss++; $display("FAIL drop_pulses: got %0d want 258", ovr_cnt); end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    bus.sample_ready = 1'b0;
    for (int i = 0; i < 5 * D + 30; i++) send_bit(1'b1, 0);
    vec++; if (bus.sample_valid !== 1'b1) begin miss++; $display("FAIL mid_buffered: got %0b want 1", bus.sample_valid); end
    do_reset();
    vec++; if (bus.sample_valid !== 1'b0 || bus.sample_out !== '0 || bus.overrun !== 1'b0 || bus.drop_cnt !== 8'd0)
      begin miss++; $display("FAIL mid_reset: got v%0b o%h ovr%0b d%0d want all 0", bus.sample_valid, bus.sample_out, bus.overrun, bus.drop_cnt); end
    bus.sample_ready = 1'b1;
    for (int i = 0; i < 8 * D; i++) send_bit(1'b1, 0);
    tick(4);
    vec++; if (got_q.size() != 5) begin miss++; $display("FAIL mid_count: got %0d want 5", got_q.size()); end
    foreach (got_q[i]) begin
      vec++; if (got_q[i] !== 32767) begin miss++; $display("FAIL mid_level%0d: got %0d want 32767", i, got_q[i]); end
    end
    vec++; if (rise_q.size() == 0 || rise_q[0] !== exp_rise_q[0]) begin miss++; $display("FAIL mid_first_rise: got %0d entries want cyc %0d", rise_q.size(), exp_rise_q[0]); end
  endtask

  initial begin
    vec  = 0;
    miss = 0;
    cyc  = 0;
    rst  = 1'b1;
    bus.bit_en       = 1'b0;
    bus.pdm_in       = 1'b0;
    bus.sample_ready = 1'b1;
    build_h();
    test_reset();
    test_dc_levels();
    test_patterns();
    test_bit_en_gaps();
    test_random();
    test_overrun();
    test_drop_saturate();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
